// File: rtl/gfx_stripe_pattern_gen.sv
// gfx_stripe_pattern_gen: raster-order test-pattern source emitting (x, y, pixel) beats on a
// valid/ready stream. Patterns: color bars, checkerboard, gradient, solid white.
// Optional build macro GFX_PATTERN_GEN_ANIMATE_EN adds a per-frame horizontal scroll offset
// applied to the checkerboard and gradient patterns.
module gfx_stripe_pattern_gen #(
    parameter int unsigned H_WIDTH     = 12,
    parameter int unsigned V_WIDTH     = 12,
    parameter int unsigned COLOR_WIDTH = 4,
    parameter int unsigned H_VISIBLE   = 800,
    parameter int unsigned V_VISIBLE   = 600
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     continuous,
    input  logic [1:0]               pattern_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     m_gfx_valid,
    input  logic                     m_gfx_ready,
    output logic [H_WIDTH-1:0]       m_gfx_x,
    output logic [V_WIDTH-1:0]       m_gfx_y,
    output logic [3*COLOR_WIDTH-1:0] m_gfx_pixel
);

    localparam int unsigned BarLen = H_VISIBLE / 8;
    localparam int unsigned BarW   = (BarLen > 1) ? $clog2(BarLen) : 1;
    localparam int unsigned PixW   = 3 * COLOR_WIDTH;

    localparam logic [H_WIDTH-1:0] XLast   = H_WIDTH'(H_VISIBLE - 1);
    localparam logic [V_WIDTH-1:0] YLast   = V_WIDTH'(V_VISIBLE - 1);
    localparam logic [BarW-1:0]    BarLast = BarW'(BarLen - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [H_WIDTH-1:0]  x_q, x_d;
    logic [V_WIDTH-1:0]  y_q, y_d;
    logic [BarW-1:0]     bar_cnt_q, bar_cnt_d;
    logic [2:0]          bar_idx_q, bar_idx_d;
    logic [1:0]          pat_q, pat_d;
    logic [PixW-1:0]     pixel_q, pixel_d;
    logic                done_q, done_d;
    logic                frame_end;
    logic [H_WIDTH-1:0]  offset_q;
    logic [H_WIDTH-1:0]  offset_next;

    // Color of one pixel; bars use the bar index, the other patterns use px = x + offset.
    function automatic logic [PixW-1:0] calc_pixel(input logic [1:0]         pat,
                                                   input logic [H_WIDTH-1:0] x,
                                                   input logic [V_WIDTH-1:0] y,
                                                   input logic [2:0]         bidx,
                                                   input logic [H_WIDTH-1:0] offset);
        logic [H_WIDTH-1:0]     px;
        logic [2:0]             idx;
        logic [COLOR_WIDTH-1:0] r, g, b;
        px  = x + offset;
        idx = 3'd7 - bidx;
        r   = '0;
        g   = '0;
        b   = '0;
        case (pat)
            2'd0: begin
                r = {COLOR_WIDTH{idx[2]}};
                g = {COLOR_WIDTH{idx[1]}};
                b = {COLOR_WIDTH{idx[0]}};
            end
            2'd1: begin
                if (px[5] ^ y[5]) begin
                    r = '1;
                    g = '1;
                    b = '1;
                end
            end
            2'd2: begin
                r = px[COLOR_WIDTH+2:3];
                g = y[COLOR_WIDTH+2:3];
                b = r ^ g;
            end
            default: begin
                r = '1;
                g = '1;
                b = '1;
            end
        endcase
        return {r, g, b};
    endfunction

`ifdef GFX_PATTERN_GEN_ANIMATE_EN
    assign offset_next = offset_q + 1'b1;

    // Scroll offset advances once per completed frame, continued or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset_q <= '0;
        end else if (frame_end) begin
            offset_q <= offset_next;
        end
    end
`else
    assign offset_q    = '0;
    assign offset_next = '0;
`endif

    // Next-state: raster walk, bar tracking and pixel lookup for the next beat.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        pat_d     = pat_q;
        pixel_d   = pixel_q;
        frame_end = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    pat_d     = pattern_sel;
                    x_d       = '0;
                    y_d       = '0;
                    bar_cnt_d = '0;
                    bar_idx_d = '0;
                    pixel_d   = calc_pixel(pattern_sel, '0, '0, 3'd0, offset_q);
                end
            end
            StRun: begin
                if (m_gfx_ready) begin
                    if (x_q == XLast && y_q == YLast) begin
                        frame_end = 1'b1;
                        x_d       = '0;
                        y_d       = '0;
                        bar_cnt_d = '0;
                        bar_idx_d = '0;
                        if (continuous) begin
                            // Next frame starts with no bubble and the updated offset.
                            pat_d   = pattern_sel;
                            pixel_d = calc_pixel(pattern_sel, '0, '0, 3'd0, offset_next);
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else if (x_q == XLast) begin
                        x_d       = '0;
                        y_d       = y_q + 1'b1;
                        bar_cnt_d = '0;
                        bar_idx_d = '0;
                        pixel_d   = calc_pixel(pat_q, '0, y_d, 3'd0, offset_q);
                    end else begin
                        x_d = x_q + 1'b1;
                        if (bar_cnt_q == BarLast) begin
                            bar_cnt_d = '0;
                            bar_idx_d = bar_idx_q + 3'd1;
                        end else begin
                            bar_cnt_d = bar_cnt_q + 1'b1;
                        end
                        pixel_d = calc_pixel(pat_q, x_d, y_q, bar_idx_d, offset_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            pixel_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            pixel_q   <= pixel_d;
            done_q    <= done_d;
        end
    end

    assign m_gfx_valid = (state_q == StRun);
    assign busy        = (state_q == StRun);
    assign done        = done_q;
    assign m_gfx_x     = x_q;
    assign m_gfx_y     = y_q;
    assign m_gfx_pixel = pixel_q;

endmodule

// File: tb/tb_gfx_stripe_pattern_gen.sv
// Scoreboard bench for gfx_stripe_pattern_gen on a 16x4 frame.
module tb_gfx_stripe_pattern_gen;

    localparam int HV = 16;
    localparam int VV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        continuous;
    logic [1:0]  pattern_sel;
    logic        busy;
    logic        done;
    logic        m_gfx_valid;
    logic        m_gfx_ready;
    logic [11:0] m_gfx_x;
    logic [11:0] m_gfx_y;
    logic [11:0] m_gfx_pixel;

    always #5 clk = ~clk;

    gfx_stripe_pattern_gen #(
        .H_WIDTH    (12),
        .V_WIDTH    (12),
        .COLOR_WIDTH(4),
        .H_VISIBLE  (HV),
        .V_VISIBLE  (VV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .pattern_sel(pattern_sel),
        .busy       (busy),
        .done       (done),
        .m_gfx_valid(m_gfx_valid),
        .m_gfx_ready(m_gfx_ready),
        .m_gfx_x    (m_gfx_x),
        .m_gfx_y    (m_gfx_y),
        .m_gfx_pixel(m_gfx_pixel)
    );

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] pix;
    } beat_t;

    beat_t       exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          done_cycle = 0;
    int          last_beat_cycle = -10;
    int          t0 = 0;
    logic        rand_rdy = 1'b0;
    logic        cap_en = 1'b0;
    logic [11:0] cap_pix[HV];
    logic [11:0] anim_q[$];
    logic [11:0] exp_off = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] model_pix(input int pat, input int x, input int y,
                                              input logic [11:0] off);
        logic [11:0] px;
        logic [11:0] yy;
        logic [2:0]  idx;
        logic [3:0]  r, g;
        px = 12'(x) + off;
        yy = 12'(y);
        case (pat)
            0: begin
                idx = 3'(7 - x / (HV / 8));
                return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
            end
            1: return (px[5] ^ yy[5]) ? 12'hFFF : 12'h000;
            2: begin
                r = px[6:3];
                g = yy[6:3];
                return {r, g, r ^ g};
            end
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic push_frame(input int pat);
        beat_t b;
        for (int yi = 0; yi < VV; yi++) begin
            for (int xi = 0; xi < HV; xi++) begin
                b.x   = 12'(xi);
                b.y   = 12'(yi);
                b.pix = model_pix(pat, xi, yi, exp_off);
                exp_q.push_back(b);
            end
        end
`ifdef GFX_PATTERN_GEN_ANIMATE_EN
        exp_off = exp_off + 12'd1;
`endif
    endtask

    task automatic start_frame(input int pat);
        @(posedge clk);
        #1;
        pattern_sel = 2'(pat);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cycle;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_gfx_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 0, 1);
    endtask

    task automatic wait_xfer(input int target, input int budget);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (xfer_cnt < target) check("xfer_timeout", 64'(xfer_cnt), 64'(target));
    endtask

    // Monitor: pop and compare on every transfer; check done placement.
    always @(negedge clk) begin
        beat_t e;
        cycle++;
        if (rst_n && m_gfx_valid && m_gfx_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                check("extra_beat", {m_gfx_x, m_gfx_y, m_gfx_pixel}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("beat", {m_gfx_x, m_gfx_y, m_gfx_pixel}, {e.x, e.y, e.pix});
            end
            if (cap_en && m_gfx_y == 12'd0) cap_pix[m_gfx_x[3:0]] = m_gfx_pixel;
            if (m_gfx_x == 12'd8 && m_gfx_y == 12'd0) anim_q.push_back(m_gfx_pixel);
            if (m_gfx_x == 12'(HV - 1) && m_gfx_y == 12'(VV - 1)) last_beat_cycle = cycle;
        end
        if (rst_n && done) begin
            done_cnt++;
            done_cycle = cycle;
            check("done_after_last", 64'(cycle - last_beat_cycle), 64'd1);
            check("done_valid_busy_low", {m_gfx_valid, busy}, 64'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int base;
        rst_n       = 1'b0;
        start       = 1'b0;
        continuous  = 1'b0;
        pattern_sel = 2'd0;
        m_gfx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", m_gfx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", m_gfx_x, 0);
        check("rst_y", m_gfx_y, 0);
        check("rst_pixel", m_gfx_pixel, 0);

        // Color bars, ready held high.
        m_gfx_ready = 1'b1;
        cap_en      = 1'b1;
        push_frame(0);
        d0 = done_cnt;
        start_frame(0);
        check("busy_after_start", busy, 1);
        wait_done(d0, 200);
        check("bars_frame_cycles", 64'(done_cycle - t0), 64'd65);
        check("bars_x0", cap_pix[0], 12'hFFF);
        check("bars_x1", cap_pix[1], 12'hFFF);
        check("bars_x2", cap_pix[2], 12'hFF0);
        check("bars_x14", cap_pix[14], 12'h000);
        cap_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bars_done_once", 64'(done_cnt - d0), 64'd1);

        // Same frame with random backpressure.
        push_frame(0);
        d0       = done_cnt;
        rand_rdy = 1'b1;
        start_frame(0);
        wait_done(d0, 2000);
        rand_rdy    = 1'b0;
        m_gfx_ready = 1'b1;
        check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

        // Continuous solid white over three frames.
        continuous = 1'b1;
        push_frame(3);
        push_frame(3);
        push_frame(3);
        d0   = done_cnt;
        base = xfer_cnt;
        start_frame(3);
        wait_xfer(base + 160, 400);
        check("cont_no_done", 64'(done_cnt - d0), 64'd0);
        continuous = 1'b0;
        wait_done(d0, 400);
        check("cont_cycles", 64'(done_cycle - t0), 64'd193);
        check("cont_beats", 64'(xfer_cnt - base), 64'd192);

        // Mid-frame start and pattern change are ignored.
        push_frame(1);
        d0   = done_cnt;
        base = xfer_cnt;
        start_frame(1);
        wait_xfer(base + 10, 100);
        start       = 1'b1;
        pattern_sel = 2'd2;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(d0, 200);
        check("midframe_beats", 64'(xfer_cnt - base), 64'd64);
        push_frame(2);
        d0 = done_cnt;
        start_frame(2);
        wait_done(d0, 200);

        // Reset at beat 20 aborts without done.
        push_frame(0);
        d0   = done_cnt;
        base = xfer_cnt;
        start_frame(0);
        wait_xfer(base + 20, 100);
        m_gfx_ready = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        check("abort_valid", m_gfx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_xy_pix", {m_gfx_x, m_gfx_y, m_gfx_pixel}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        m_gfx_ready = 1'b1;
        exp_q.delete();
        exp_off = '0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

`ifdef GFX_PATTERN_GEN_ANIMATE_EN
        // Gradient scrolls one pixel per frame.
        continuous = 1'b1;
        for (int f = 0; f < 9; f++) push_frame(2);
        anim_q.delete();
        d0   = done_cnt;
        base = xfer_cnt;
        start_frame(2);
        wait_xfer(base + 8 * 64 + 10, 1000);
        continuous = 1'b0;
        wait_done(d0, 200);
        check("anim_frames", 64'(anim_q.size()), 64'd9);
        if (anim_q.size() == 9) begin
            check("anim_f1_red", anim_q[0][11:8], 4'd1);
            check("anim_f2_red", anim_q[1][11:8], 4'd1);
            check("anim_f9_red", anim_q[8][11:8], 4'd2);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
